// File: rtl/scd_mem_pkg.sv
// Shared definitions for the scd_mem_ctrl slice: access size codes, the
// controller FSM encoding, the default RAM word-address width, and the
// request legality rule.
package scd_mem_pkg;

  localparam int ADDR_W_DEF = 5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RWAIT = 3'd2,
    ST_RCAP  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  // A request is rejected for the illegal size code or a misaligned
  // halfword/word byte offset.
  function automatic logic is_rejected(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'b11) ||
           ((size == SZ_HALF) && off[0]) ||
           ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/scd_mem_ctrl_lane.sv
// scd_lane_unit: combinational byte-lane steering for little-endian access.
//   word     in  32  RAM read word
//   off      in  2   byte offset within the word (addr[1:0])
//   size     in  2   access size code
//   sext     in  1   sign-extend sub-word load results
//   wdata    in  32  right-justified store data
//   load_val out 32  selected lane, sign- or zero-extended
//   merged   out 32  word with the addressed lane replaced by wdata
module scd_lane_unit
  import scd_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = word[{off, 3'b000} +: 8];
  assign half_lane = word[{off[1], 4'b0000} +: 16];

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statement leaves it unassigned (which would infer a latch).
  always_comb begin
    load_val = word;
    merged   = word;
    case (size)
      SZ_BYTE: begin
        load_val = {{24{sext & byte_lane[7]}}, byte_lane};
        merged[{off, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_val = {{16{sext & half_lane[15]}}, half_lane};
        merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_val = word;
        merged   = wdata;
      end
    endcase
  end

endmodule

// File: rtl/scd_mem_ctrl.sv
// scd_mem_ctrl: req/ack initiator for a synchronous data RAM with registered
// inputs and a registered output (two-edge read latency). Sub-word stores
// are done as read-modify-write since the RAM has no byte enables.
//   clk, clrn      clock, asynchronous active-low reset
//   req/wr/size/sext/addr/wdata   CPU request, captured at acceptance
//   busy/ack/err/rdata            CPU response
//   m_addr/m_we/m_din/m_dout      RAM port
module scd_mem_ctrl
  import scd_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] m_addr,
  output logic        m_we,
  output logic [31:0] m_din,
  input  logic [31:0] m_dout
);

  state_t      state;
  logic [1:0]  off_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [31:0] wdata_q;

  logic [31:0] load_val;
  logic [31:0] merged;

  // Upper address bits alias away; they are intentionally ignored.
  logic addr_unused;
  assign addr_unused = ^addr[31:ADDR_W+2];

  assign busy = (state != ST_IDLE);

  // The RAM's read word arrives in RCAP; one lane unit serves both the load
  // extraction and the store merge.
  scd_lane_unit u_lane (
    .word     (m_dout),
    .off      (off_q),
    .size     (size_q),
    .sext     (sext_q),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  // NOTE: all state below is written with non-blocking assignments so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= ST_IDLE;
      off_q   <= 2'b00;
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sext_q  <= 1'b0;
      wdata_q <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      m_addr  <= '0;
      m_we    <= 1'b0;
      m_din   <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            off_q   <= addr[1:0];
            wr_q    <= wr;
            size_q  <= size;
            sext_q  <= sext;
            wdata_q <= wdata;
            m_addr  <= {{(30-ADDR_W){1'b0}}, addr[ADDR_W+1:2], 2'b00};
            if (is_rejected(size, addr[1:0])) begin
              ack <= 1'b1;
              err <= 1'b1;
            end else if (wr && (size == SZ_WORD)) begin
              // Full-word stores need no read, go straight to the write cycle.
              m_din <= wdata;
              m_we  <= 1'b1;
              state <= ST_WRITE;
            end else begin
              state <= ST_RADDR;
            end
          end
        end
        ST_RADDR: state <= ST_RWAIT;
        ST_RWAIT: state <= ST_RCAP;
        ST_RCAP: begin
          if (wr_q) begin
            m_din <= merged;
            m_we  <= 1'b1;
            state <= ST_WRITE;
          end else begin
            rdata <= load_val;
            ack   <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          m_we  <= 1'b0;
          ack   <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          m_we  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scd_mem_ctrl.sv
// Self-checking bench for scd_mem_ctrl: a behavioural RAM, a byte-array
// reference model, directed scenarios and a randomized sequence.
module tb_scd_mem_ctrl;

  logic        clk = 1'b0;
  logic        clrn;
  logic        req, wr, sext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, ack, err, m_we;
  logic [31:0] rdata, m_addr, m_din, m_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scd_mem_ctrl dut (
    .clk    (clk),
    .clrn   (clrn),
    .req    (req),
    .wr     (wr),
    .size   (size),
    .sext   (sext),
    .addr   (addr),
    .wdata  (wdata),
    .busy   (busy),
    .ack    (ack),
    .err    (err),
    .rdata  (rdata),
    .m_addr (m_addr),
    .m_we   (m_we),
    .m_din  (m_din),
    .m_dout (m_dout)
  );

  // Synchronous RAM: address registered at one edge, data out at the next.
  logic [31:0] ram [32];
  logic [4:0]  ram_addr_q;
  always @(posedge clk) begin
    if (m_we) ram[m_addr[6:2]] <= m_din;
    ram_addr_q <= m_addr[6:2];
    m_dout     <= ram[ram_addr_q];
  end

  // Reference model: 128 bytes, little-endian, no notion of RAM timing.
  logic [7:0]  ref_mem [128];
  logic [31:0] last_rdata;
  logic [31:0] obs_rdata;

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic sx);
    int base, n;
    logic [31:0] v;
    base = int'(a[6:0]);
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
    if (sx && n < 4 && v[8 * n - 1]) v = v | ~((32'h1 << (8 * n)) - 1);
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int base, n;
    base = int'(a[6:0]);
    n = 1 << sz;
    for (int i = 0; i < n; i++) ref_mem[base + i] = 8'(wd >> (8 * i));
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request at the current negedge (DUT idle or in an ack cycle)
  // and return at the negedge of its ack cycle. With poke set, req is held
  // high with a word store while busy, which must be ignored.
  task automatic op(input logic w, input logic [1:0] sz, input logic sx,
                    input logic [31:0] a, input logic [31:0] wd, input logic poke);
    logic        rej;
    int          exp_lat, lat, we_cnt;
    logic        got_err, got_busy;
    logic [31:0] got_rd, got_ma, exp_rd;
    rej = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    if (rej)               exp_lat = 1;
    else if (!w)           exp_lat = 4;
    else if (sz == 2'b10)  exp_lat = 2;
    else                   exp_lat = 5;
    got_err = 1'bx; got_busy = 1'bx; got_rd = 'x; got_ma = 'x;
    req = 1'b1; wr = w; size = sz; sext = sx; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0; wr = 1'($urandom); size = 2'($urandom); sext = 1'($urandom);
    addr = $urandom; wdata = $urandom;
    lat = 0; we_cnt = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (m_we === 1'b1) we_cnt++;
      if (ack === 1'b1) begin
        lat = n; got_err = err; got_busy = busy; got_rd = rdata; got_ma = m_addr;
        req = 1'b0;
        break;
      end
      if (poke) begin
        req = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h40; wdata = 32'hDEADBEEF;
      end
    end
    check("ack_cycle", lat, exp_lat);
    check("err", 32'(got_err), 32'(rej));
    check("busy_at_ack", 32'(got_busy), 0);
    check("we_pulses", we_cnt, (w && !rej) ? 1 : 0);
    if (!rej) check("m_addr", got_ma, {25'b0, a[6:2], 2'b00});
    if (!rej && !w) begin
      exp_rd = model_load(a, sz, sx);
      last_rdata = exp_rd;
    end else begin
      exp_rd = last_rdata;
    end
    check("rdata", got_rd, exp_rd);
    if (!rej && w) model_store(a, sz, wd);
    obs_rdata = got_rd;
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("no_extra_ack", 32'(ack), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_ack"}, 32'(ack), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_m_we"}, 32'(m_we), 0);
    check({tag, "_m_addr"}, m_addr, 0);
    check({tag, "_m_din"}, m_din, 0);
  endtask

  initial begin
    logic        rw, rsx;
    logic [1:0]  rsz;
    logic [31:0] ra;
    for (int i = 0; i < 32; i++) ram[i] = '0;
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    last_rdata = '0;
    clrn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0;
    addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    clrn = 1'b1;
    @(negedge clk);

    // Word store then word load.
    op(1'b1, 2'b10, 1'b0, 32'h08, 32'h12345678, 1'b0);
    idle_check();
    op(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0);
    check("lit_word", obs_rdata, 32'h12345678);
    idle_check();

    // Byte store (read-modify-write) then word load.
    op(1'b1, 2'b00, 1'b0, 32'h09, 32'hFFFFFFAB, 1'b0);
    idle_check();
    op(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0);
    check("lit_rmw", obs_rdata, 32'h1234AB78);
    idle_check();

    // Sub-word loads with sign and zero extension.
    op(1'b1, 2'b10, 1'b0, 32'h08, 32'h8001ABCD, 1'b0);
    op(1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, 1'b0);
    check("lit_half_sext", obs_rdata, 32'hFFFF8001);
    op(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, 1'b0);
    check("lit_half_zext", obs_rdata, 32'h00008001);
    op(1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, 1'b0);
    check("lit_byte_sext", obs_rdata, 32'hFFFFFF80);
    idle_check();

    // Rejects: misaligned word load and illegal size.
    op(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b0);
    idle_check();
    op(1'b1, 2'b11, 1'b0, 32'h10, 32'h55555555, 1'b0);
    idle_check();

    // Back-to-back: each new req issued in the previous ack cycle.
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D, 1'b0);
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    op(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000003C, 1'b0);
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    check("lit_b2b", obs_rdata, 32'hCA3CF00D);
    idle_check();

    // req held high while busy is ignored; 0x40 must stay untouched.
    op(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b1);
    idle_check();
    op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);
    check("lit_busy_ignored", obs_rdata, 32'h0);
    idle_check();

    // Reset during RWAIT of a byte store: abandoned, no ack, no write.
    req = 1'b1; wr = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h08; wdata = 32'h77;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b0;
    #1;
    check_reset_outputs("midop");
    last_rdata = '0;
    @(negedge clk);
    clrn = 1'b1;
    for (int i = 0; i < 6; i++) idle_check();
    op(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0);
    check("lit_after_reset", obs_rdata, 32'h8001ABCD);
    op(1'b0, 2'b10, 1'b0, 32'h88, 32'h0, 1'b0);
    check("lit_alias", obs_rdata, 32'h8001ABCD);
    idle_check();

    // Randomized mix, mostly aligned, checked against the byte model.
    for (int i = 0; i < 60; i++) begin
      rw  = 1'($urandom);
      rsz = 2'($urandom_range(0, 3));
      rsx = 1'($urandom);
      ra  = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) begin
        if (rsz == 2'b01) ra[0] = 1'b0;
        if (rsz == 2'b10) ra[1:0] = 2'b00;
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      op(rw, rsz, rsx, ra, $urandom, 1'($urandom_range(0, 3) == 0));
    end
    idle_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
